// File: rtl/mult_dispatch_pkg.sv
// Shared types and helpers for the multiplier dispatch block.
package mult_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } disp_state_t;

  // Packed width of one FIFO entry: two operands plus the optional tag.
  function automatic int unsigned pair_width(input int unsigned width, input int unsigned tag_w,
                                             input bit tag_en);
    return 2 * width + (tag_en ? tag_w : 0);
  endfunction

endpackage

// File: rtl/mult_dispatch_fifo.sv
// Synchronous operand FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module mult_dispatch_fifo
  import mult_dispatch_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mult_dispatch.sv
// Issue stage for the sequential multiplier: FIFO -> start/done handshake -> result register.
// Define MULT_DISPATCH_TAG_EN to carry a per-operation tag from in_tag through to res_tag.
module mult_dispatch
  import mult_dispatch_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_mcand,
  input  logic [WIDTH-1:0]       in_mplier,
`ifdef MULT_DISPATCH_TAG_EN
  input  logic [TAG_W-1:0]       in_tag,
  output logic [TAG_W-1:0]       res_tag,
`endif
  output logic                   mult_start,
  output logic [WIDTH-1:0]       mult_mcand,
  output logic [WIDTH-1:0]       mult_mplier,
  input  logic [WIDTH-1:0]       mult_product,
  input  logic                   mult_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_product,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   timeout_err
);

`ifdef MULT_DISPATCH_TAG_EN
  localparam bit TagEn = 1'b1;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
  } pair_t;
`else
  localparam bit TagEn = 1'b0;
  typedef struct packed {
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
  } pair_t;
`endif

  localparam int unsigned EntryW = pair_width(WIDTH, TAG_W, TagEn);
  localparam int unsigned CntW   = $clog2(TIMEOUT + 1);

  disp_state_t     state_q, state_d;
  pair_t           in_pair, head_pair;
  logic            fifo_full, fifo_empty;
  logic            issue, capture, tmo;
  logic            res_free, done_rise, cnt_hit;
  logic            done_q;
  logic [CntW-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, res_product_q;
  logic            res_valid_q, timeout_err_q;

  always_comb begin
    in_pair        = '0;
    in_pair.mcand  = in_mcand;
    in_pair.mplier = in_mplier;
`ifdef MULT_DISPATCH_TAG_EN
    in_pair.tag    = in_tag;
`endif
  end

  mult_dispatch_fifo #(
    .DW    (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (in_valid & in_ready),
    .pop     (issue),
    .wdata   (in_pair),
    .rdata   (head_pair),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Held low while reset is asserted so every output reads 0 during reset.
  assign in_ready  = ~fifo_full & reset_n;
  assign res_free  = ~res_valid_q | res_ready;
  assign done_rise = mult_done & ~done_q;
  assign cnt_hit   = (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!fifo_empty && res_free) state_d = START;
      START: state_d = BUSY;
      BUSY:  if (done_rise || cnt_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue      = (state_q == IDLE) & ~fifo_empty & res_free;
    mult_start = (state_q == START);
    capture    = (state_q == BUSY) & done_rise;
    tmo        = (state_q == BUSY) & ~done_rise & cnt_hit;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q        <= 1'b0;
      cnt_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      done_q <= mult_done;
      if (issue) begin
        mcand_q  <= head_pair.mcand;
        mplier_q <= head_pair.mplier;
      end
      if (mult_start)             cnt_q <= '0;
      else if (state_q == BUSY)   cnt_q <= cnt_q + 1'b1;
      if (tmo) timeout_err_q <= 1'b1;
      if (capture) begin
        res_valid_q   <= 1'b1;
        res_product_q <= mult_product;
      end else if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

`ifdef MULT_DISPATCH_TAG_EN
  logic [TAG_W-1:0] op_tag_q, res_tag_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_tag_q  <= '0;
      res_tag_q <= '0;
    end else begin
      if (issue)   op_tag_q  <= head_pair.tag;
      if (capture) res_tag_q <= op_tag_q;
    end
  end

  assign res_tag = res_tag_q;
`endif

  assign mult_mcand  = mcand_q;
  assign mult_mplier = mplier_q;
  assign res_valid   = res_valid_q;
  assign res_product = res_product_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mult_dispatch.sv
// Directed bench for mult_dispatch; the bench itself plays the multiplier on the start/done side.
module tb_mult_dispatch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mcand, in_mplier;
`ifdef MULT_DISPATCH_TAG_EN
  logic [3:0]  in_tag;
  logic [3:0]  res_tag;
`endif
  logic        mult_start;
  logic [15:0] mult_mcand, mult_mplier, mult_product;
  logic        mult_done;
  logic        res_valid, res_ready;
  logic [15:0] res_product;
  logic [2:0]  fifo_count;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mult_dispatch dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mcand     (in_mcand),
    .in_mplier    (in_mplier),
`ifdef MULT_DISPATCH_TAG_EN
    .in_tag       (in_tag),
    .res_tag      (res_tag),
`endif
    .mult_start   (mult_start),
    .mult_mcand   (mult_mcand),
    .mult_mplier  (mult_mplier),
    .mult_product (mult_product),
    .mult_done    (mult_done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_product  (res_product),
    .fifo_count   (fifo_count),
    .timeout_err  (timeout_err)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    in_valid  = 1'b1;
    in_mcand  = a;
    in_mplier = b;
    tick();
    in_valid  = 1'b0;
  endtask

  // Waits (bounded) for mult_start, checks operands, answers with a done edge, checks the result.
  task automatic run_op(input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ep,
                        input string name);
    int n = 0;
    while (mult_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (mult_start !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_start: mult_start=%b required 1 within 20 cycles", name, mult_start);
      return;
    end
    n_cmp++;
    if (mult_mcand !== ea || mult_mplier !== eb) begin
      n_bad++;
      $display("FAIL %s_operands: got %h,%h required %h,%h", name, mult_mcand, mult_mplier, ea, eb);
    end
    tick();
    mult_product = mult_mcand * mult_mplier;
    mult_done    = 1'b1;
    tick();
    mult_done    = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b1 || res_product !== ep) begin
      n_bad++;
      $display("FAIL %s_result: valid=%b product=%h required valid=1 product=%h",
               name, res_valid, res_product, ep);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({in_ready, mult_start, res_valid, timeout_err, fifo_count} !== 7'b0 ||
        mult_mcand !== 16'h0 || mult_mplier !== 16'h0 || res_product !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b st=%b rv=%b err=%b cnt=%0d mc=%h mp=%h rp=%h req all 0",
               in_ready, mult_start, res_valid, timeout_err, fifo_count, mult_mcand, mult_mplier,
               res_product);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_release: in_ready=%b fifo_count=%0d required 1,0", in_ready, fifo_count);
    end
  endtask

  task automatic test_basic;
    push(16'd2, 16'd3);
    n_cmp++;
    if (fifo_count !== 3'd1 || mult_start !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_cycle1: fifo_count=%0d start=%b required 1,0", fifo_count, mult_start);
    end
    tick();
    n_cmp++;
    if (mult_start !== 1'b1 || mult_mcand !== 16'd2 || mult_mplier !== 16'd3 ||
        fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL basic_start: start=%b mc=%h mp=%h cnt=%0d required 1,0002,0003,0",
               mult_start, mult_mcand, mult_mplier, fifo_count);
    end
    tick();
    n_cmp++;
    if (mult_start !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse: mult_start=%b required 0 one cycle after start", mult_start);
    end
    mult_product = 16'h0006;
    mult_done    = 1'b1;
    tick();
    mult_done    = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b1 || res_product !== 16'h0006) begin
      n_bad++;
      $display("FAIL basic_result: valid=%b product=%h required 1,0006", res_valid, res_product);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_consume: res_valid=%b required 0", res_valid);
    end
  endtask

  task automatic test_back_to_back;
    res_ready = 1'b1;
    push(16'hFFFF, 16'd3);
    push(16'hFFEC, 16'd5);
    run_op(16'hFFFF, 16'd3, 16'hFFFD, "b2b_first");
    run_op(16'hFFEC, 16'd5, 16'hFF9C, "b2b_second");
    tick();
  endtask

  task automatic test_fifo_full;
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(16'(i), 16'(i));
    n_cmp++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_fill: fifo_count=%0d in_ready=%b required 4,0", fifo_count, in_ready);
    end
    push(16'd6, 16'd6);
    n_cmp++;
    if (fifo_count !== 3'd4) begin
      n_bad++;
      $display("FAIL full_reject: fifo_count=%0d required 4", fifo_count);
    end
    mult_product = 16'd1;
    mult_done    = 1'b1;
    tick();
    mult_done    = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b1 || res_product !== 16'd1) begin
      n_bad++;
      $display("FAIL full_first: valid=%b product=%h required 1,0001", res_valid, res_product);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (mult_start !== 1'b0 || fifo_count !== 3'd4) begin
        n_bad++;
        $display("FAIL full_hold: start=%b fifo_count=%0d required 0,4", mult_start, fifo_count);
      end
    end
    res_ready = 1'b1;
    run_op(16'd2, 16'd2, 16'd4, "full_drain2");
    run_op(16'd3, 16'd3, 16'd9, "full_drain3");
    run_op(16'd4, 16'd4, 16'd16, "full_drain4");
    run_op(16'd5, 16'd5, 16'd25, "full_drain5");
    tick();
    n_cmp++;
    if (fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL full_empty: fifo_count=%0d required 0", fifo_count);
    end
  endtask

  task automatic test_stale_done;
    int n = 0;
    res_ready    = 1'b1;
    mult_product = 16'hDEAD;
    mult_done    = 1'b1;
    tick();
    push(16'd7, 16'd6);
    while (mult_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (mult_start !== 1'b1 || mult_mcand !== 16'd7) begin
      n_bad++;
      $display("FAIL stale_start: start=%b mcand=%h required 1,0007", mult_start, mult_mcand);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (res_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stale_ignored: res_valid=%b required 0 while done held", res_valid);
      end
    end
    mult_done = 1'b0;
    tick();
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stale_fall: res_valid=%b required 0", res_valid);
    end
    mult_product = 16'd42;
    mult_done    = 1'b1;
    tick();
    mult_done    = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b1 || res_product !== 16'd42) begin
      n_bad++;
      $display("FAIL stale_capture: valid=%b product=%h required 1,002a", res_valid, res_product);
    end
    tick();
  endtask

  task automatic test_timeout;
    int n = 0;
    res_ready = 1'b1;
    mult_done = 1'b0;
    push(16'd9, 16'd9);
    push(16'd3, 16'd4);
    while (mult_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (mult_start !== 1'b1 || mult_mcand !== 16'd9) begin
      n_bad++;
      $display("FAIL tmo_start: start=%b mcand=%h required 1,0009", mult_start, mult_mcand);
    end
    repeat (255) tick();
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_early: timeout_err=%b required 0 after 254 busy cycles", timeout_err);
    end
    tick();
    n_cmp++;
    if (timeout_err !== 1'b1 || res_valid !== 1'b0 || mult_start !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_set: err=%b valid=%b start=%b required 1,0,0",
               timeout_err, res_valid, mult_start);
    end
    tick();
    n_cmp++;
    if (mult_start !== 1'b1 || mult_mcand !== 16'd3) begin
      n_bad++;
      $display("FAIL tmo_next: start=%b mcand=%h required 1,0003", mult_start, mult_mcand);
    end
    run_op(16'd3, 16'd4, 16'd12, "tmo_after");
    tick();
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_sticky: timeout_err=%b required 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    res_ready = 1'b0;
    push(16'd2, 16'd2);
    push(16'd3, 16'd3);
    push(16'd4, 16'd4);
    while (mult_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, mult_start, res_valid, timeout_err, fifo_count} !== 7'b0 ||
        mult_mcand !== 16'h0 || mult_mplier !== 16'h0 || res_product !== 16'h0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: rdy=%b st=%b rv=%b err=%b cnt=%0d mc=%h mp=%h req all 0",
               in_ready, mult_start, res_valid, timeout_err, fifo_count, mult_mcand, mult_mplier);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (mult_start !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_idle: start=%b cnt=%0d rdy=%b valid=%b required 0,0,1,0",
                 mult_start, fifo_count, in_ready, res_valid);
      end
    end
  endtask

`ifdef MULT_DISPATCH_TAG_EN
  task automatic test_tags;
    res_ready = 1'b1;
    in_tag = 4'd1;
    push(16'd10, 16'd2);
    in_tag = 4'd2;
    push(16'd11, 16'd2);
    in_tag = 4'd0;
    run_op(16'd10, 16'd2, 16'd20, "tag_first");
    n_cmp++;
    if (res_tag !== 4'd1) begin
      n_bad++;
      $display("FAIL tag_first_tag: res_tag=%0d required 1", res_tag);
    end
    run_op(16'd11, 16'd2, 16'd22, "tag_second");
    n_cmp++;
    if (res_tag !== 4'd2) begin
      n_bad++;
      $display("FAIL tag_second_tag: res_tag=%0d required 2", res_tag);
    end
    tick();
  endtask
`endif

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_mcand     = '0;
    in_mplier    = '0;
    mult_product = '0;
    mult_done    = 1'b0;
    res_ready    = 1'b0;
`ifdef MULT_DISPATCH_TAG_EN
    in_tag       = '0;
`endif
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_fifo_full();
    test_stale_done();
    test_timeout();
    test_reset_mid();
`ifdef MULT_DISPATCH_TAG_EN
    test_tags();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
